// File: rtl/mem_port_arb_pkg.sv
// Shared types and default widths for the main-memory port arbiter.
// Latency: n/a (types only). Backpressure: n/a.
// Used by mem_port_arbiter and arb_age_counter.
package mem_port_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        HOST_RD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating count of cycles a host request has been waiting; age_hit forces one host win.
// Latency: age_hit reflects the registered count, updated every clock.
// Backpressure: none; clear has priority over increment.
import mem_port_arb_pkg::*;

module arb_age_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic age_hit
);

    logic [3:0] age;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age <= '0;
        end else if (clr) begin
            age <= '0;
        end else if (inc && (age != 4'(MAX_WAIT))) begin
            age <= age + 4'd1;
        end
    end

    assign age_hit = (age == 4'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sync-RAM port between CPU and host; MEM_PORT_ARB_HALT_EN adds host_halt.
// Latency: CPU write 1 cycle, CPU read 2 cycles, host read data 1 cycle after host_gnt.
// Backpressure: cpu_ss=0 stalls the CPU; host_req is held until host_gnt.
import mem_port_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ss,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
`ifdef MEM_PORT_ARB_HALT_EN
    input  logic              host_halt,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state, state_nxt;
    logic              halt;
    logic              age_hit;
    logic              cpu_req;
    logic              host_win;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;

`ifdef MEM_PORT_ARB_HALT_EN
    assign halt = host_halt;
`else
    assign halt = 1'b0;
`endif

    assign cpu_req  = cpu_rd | cpu_wr;
    assign host_win = host_req & (halt | age_hit | ~cpu_req);

    arb_age_counter #(
        .MAX_WAIT (HOST_MAX_WAIT)
    ) u_age (
        .clk     (clk),
        .rst     (rst),
        .inc     (host_req),
        .clr     (host_gnt | ~host_req),
        .age_hit (age_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == CPU_RD)  cpu_rdata_q  <= mem_rdata;
            if (state == HOST_RD) host_rdata_q <= mem_rdata;
        end
    end

    // Outputs are forced quiet while rst is low because IDLE alone would raise cpu_ss.
    always_comb begin
        state_nxt   = state;
        cpu_ss      = 1'b0;
        host_gnt    = 1'b0;
        host_rvalid = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = cpu_addr;
        mem_wdata   = cpu_wdata;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (host_win) begin
                        host_gnt  = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = host_we;
                        mem_addr  = host_addr;
                        mem_wdata = host_wdata;
                        if (!host_we) state_nxt = HOST_RD;
                    end else if (!halt) begin
                        if (cpu_wr) begin
                            mem_en = 1'b1;
                            mem_we = 1'b1;
                            cpu_ss = 1'b1;
                        end else if (cpu_rd) begin
                            mem_en    = 1'b1;
                            state_nxt = CPU_RD;
                        end else begin
                            cpu_ss = 1'b1;
                        end
                    end
                end
                CPU_RD: begin
                    cpu_ss    = ~halt;
                    state_nxt = IDLE;
                end
                HOST_RD: begin
                    host_rvalid = 1'b1;
                    state_nxt   = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign cpu_rdata  = (state == CPU_RD)  ? mem_rdata : cpu_rdata_q;
    assign host_rdata = (state == HOST_RD) ? mem_rdata : host_rdata_q;

endmodule
